// File: rtl/vram_console_ctrl.sv
// VRAM write-port sequencer: CPU stores win, console engine fills the gaps.
// Optional per-line auto-clear on row advance: define VRAM_LINE_AUTOCLR_EN.
module vram_console_ctrl #(
  parameter int unsigned COLS      = 32,
  parameter int unsigned ROWS      = 24,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_we,
  input  logic [13:0]               cpu_a,
  input  logic [31:0]               cpu_wd,
  input  logic                      ch_valid,
  input  logic [7:0]                ch_data,
  input  logic [23:0]               ch_color,
  output logic                      ch_ready,
  input  logic                      clr_req,
  output logic                      busy,
  output logic                      vram_we,
  output logic [13:0]               vram_a,
  output logic [31:0]               vram_wd,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic [$clog2(ROWS)-1:0]   cur_row
);

  localparam int unsigned ColW    = $clog2(COLS);
  localparam int unsigned RowW    = $clog2(ROWS);
  localparam logic [11:0] LastIdx = 12'(COLS * ROWS - 1);
  localparam logic [31:0] FillWd  = {24'h000000, FILL_CHAR};

`ifdef VRAM_LINE_AUTOCLR_EN
  typedef enum logic [1:0] {StIdle, StPut, StClear, StLclr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPut, StClear} state_e;
`endif

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              clr_pend_q, clr_pend_d;
  logic [11:0]       idx_q, idx_d;
  logic [31:0]       put_wd_q, put_wd_d;
  logic              put_adv_q, put_adv_d;
  logic              vram_we_q, vram_we_d;
  logic [13:0]       vram_a_q, vram_a_d;
  logic [31:0]       vram_wd_q, vram_wd_d;

  logic [11:0]       cur_idx;
  logic [RowW-1:0]   new_row;

  assign cur_idx = 12'(row_q) * 12'(COLS) + 12'(col_q);
  assign new_row = (row_q == RowW'(ROWS - 1)) ? '0 : row_q + 1'b1;

  assign ch_ready = !reset && (state_q == StIdle) && !clr_pend_q && !clr_req;
  assign busy     = (state_q != StIdle) || clr_pend_q;
  assign vram_we  = vram_we_q;
  assign vram_a   = vram_a_q;
  assign vram_wd  = vram_wd_q;
  assign cur_col  = col_q;
  assign cur_row  = row_q;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    clr_pend_d = clr_pend_q | clr_req;
    idx_d      = idx_q;
    put_wd_d   = put_wd_q;
    put_adv_d  = put_adv_q;
    vram_we_d  = 1'b0;
    vram_a_d   = vram_a_q;
    vram_wd_d  = vram_wd_q;

    // CPU owns the port this cycle; the engine simply does not advance.
    if (cpu_we) begin
      vram_we_d = 1'b1;
      vram_a_d  = cpu_a;
      vram_wd_d = cpu_wd;
    end

    case (state_q)
      StIdle: begin
        if (clr_pend_q || clr_req) begin
          state_d = StClear;
          idx_d   = '0;
        end else if (ch_valid) begin
          put_wd_d  = {ch_color, ch_data};
          put_adv_d = 1'b1;
          case (ch_data)
            8'h0A: begin
              col_d = '0;
              row_d = new_row;
`ifdef VRAM_LINE_AUTOCLR_EN
              state_d = StLclr;
              idx_d   = 12'(new_row) * 12'(COLS);
`endif
            end
            8'h0D: col_d = '0;
            8'h08: begin
              if (col_q != '0) begin
                col_d     = col_q - 1'b1;
                put_wd_d  = FillWd;
                put_adv_d = 1'b0;
                state_d   = StPut;
              end
            end
            default: state_d = StPut;
          endcase
        end
      end
      StPut: begin
        if (!cpu_we) begin
          vram_we_d = 1'b1;
          vram_a_d  = {cur_idx, 2'b00};
          vram_wd_d = put_wd_q;
          state_d   = StIdle;
          if (put_adv_q) begin
            if (col_q == ColW'(COLS - 1)) begin
              col_d = '0;
              row_d = new_row;
`ifdef VRAM_LINE_AUTOCLR_EN
              state_d = StLclr;
              idx_d   = 12'(new_row) * 12'(COLS);
`endif
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      StClear: begin
        if (!cpu_we) begin
          vram_we_d = 1'b1;
          vram_a_d  = {idx_q, 2'b00};
          vram_wd_d = FillWd;
          if (idx_q == LastIdx) begin
            col_d      = '0;
            row_d      = '0;
            clr_pend_d = 1'b0;
            state_d    = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef VRAM_LINE_AUTOCLR_EN
      StLclr: begin
        if (!cpu_we) begin
          vram_we_d = 1'b1;
          vram_a_d  = {idx_q, 2'b00};
          vram_wd_d = FillWd;
          if (idx_q == 12'(row_q) * 12'(COLS) + 12'(COLS - 1)) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      clr_pend_q <= 1'b0;
      idx_q      <= '0;
      put_wd_q   <= '0;
      put_adv_q  <= 1'b0;
      vram_we_q  <= 1'b0;
      vram_a_q   <= '0;
      vram_wd_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      clr_pend_q <= clr_pend_d;
      idx_q      <= idx_d;
      put_wd_q   <= put_wd_d;
      put_adv_q  <= put_adv_d;
      vram_we_q  <= vram_we_d;
      vram_a_q   <= vram_a_d;
      vram_wd_q  <= vram_wd_d;
    end
  end

endmodule

// File: tb/tb_vram_console_ctrl.sv
// Directed bench for vram_console_ctrl; VRAM writes are logged at negedge.
module tb_vram_console_ctrl;

`ifdef VRAM_LINE_AUTOCLR_EN
  localparam int LineW = 32;
`else
  localparam int LineW = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_a = '0;
  logic [31:0] cpu_wd = '0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = '0;
  logic [23:0] ch_color = '0;
  logic        ch_ready;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        vram_we;
  logic [13:0] vram_a;
  logic [31:0] vram_wd;
  logic [4:0]  cur_col;
  logic [4:0]  cur_row;

  int n_total = 0;
  int n_bad   = 0;
  logic [45:0] wq[$];

  vram_console_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_we   (cpu_we),
    .cpu_a    (cpu_a),
    .cpu_wd   (cpu_wd),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_color (ch_color),
    .ch_ready (ch_ready),
    .clr_req  (clr_req),
    .busy     (busy),
    .vram_we  (vram_we),
    .vram_a   (vram_a),
    .vram_wd  (vram_wd),
    .cur_col  (cur_col),
    .cur_row  (cur_row)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (vram_we) wq.push_back({vram_a, vram_wd});

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [23:0] c);
    int n = 0;
    ch_valid = 1'b1;
    ch_data  = d;
    ch_color = c;
    #1;
    while (!ch_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("send_accept", 64'(n < 100), 64'd1);
    tick();
    ch_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check_eq("idle_timeout", 64'(n < 500), 64'd1);
    tick();
  endtask

  task automatic check_cur(input string tag, input int col, input int row);
    check_eq({tag, "_col"}, 64'(cur_col), 64'(col));
    check_eq({tag, "_row"}, 64'(cur_row), 64'(row));
  endtask

  initial begin
    int cyc;
    int n_fill;
    int n_cpu;
    int n_order;

    // Reset
    tick();
    check_eq("rst_ready", 64'(ch_ready), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_we", 64'(vram_we), 64'd0);
    check_eq("rst_ready_after", 64'(ch_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_cur("rst", 0, 0);

    // Plain put
    send(8'h41, 24'h00ff00);
    tick();
    check_eq("a_we", 64'(vram_we), 64'd1);
    check_eq("a_addr", 64'(vram_a), 64'h000);
    check_eq("a_wd", 64'(vram_wd), 64'h00ff0041);
    check_cur("a", 1, 0);
    tick();

    // CPU collides with the engine write
    send(8'h43, 24'h123456);
    cpu_we = 1'b1;
    cpu_a  = 14'h010;
    cpu_wd = 32'hff000042;
    tick();
    cpu_we = 1'b0;
    check_eq("col_cpu_we", 64'(vram_we), 64'd1);
    check_eq("col_cpu_addr", 64'(vram_a), 64'h010);
    check_eq("col_cpu_wd", 64'(vram_wd), 64'hff000042);
    tick();
    check_eq("col_eng_we", 64'(vram_we), 64'd1);
    check_eq("col_eng_addr", 64'(vram_a), 64'h004);
    check_eq("col_eng_wd", 64'(vram_wd), 64'h12345643);
    check_cur("col", 2, 0);
    wait_idle();

    // Walk cursor to (31,23)
    wq.delete();
    send(8'h0D, 24'h0);
    wait_idle();
    for (int i = 0; i < 23; i++) begin
      send(8'h0A, 24'h0);
      wait_idle();
    end
    check_eq("nl_writes", 64'(wq.size()), 64'(23 * LineW));
    check_cur("walk_row", 0, 23);
    for (int i = 0; i < 31; i++) begin
      send(8'h78, 24'h0);
      wait_idle();
    end
    check_cur("walk", 31, 23);

    wq.delete();
    send(8'h5A, 24'h000000);
    wait_idle();
    check_eq("z_count", 64'(wq.size()), 64'(1 + LineW));
    if (wq.size() > 0) check_eq("z_write", 64'(wq[0]), 64'({14'hBFC, 32'h0000005A}));
    check_cur("z_wrap", 0, 0);

    wq.delete();
    send(8'h0A, 24'h0);
    wait_idle();
    check_eq("lf_count", 64'(wq.size()), 64'(LineW));
    check_cur("lf", 0, 1);

    wq.delete();
    send(8'h08, 24'h0);
    wait_idle();
    check_eq("bs0_count", 64'(wq.size()), 64'd0);
    check_cur("bs0", 0, 1);

    // Backspace with col>0 blanks the previous cell
    wq.delete();
    send(8'h51, 24'h0000ff);
    wait_idle();
    send(8'h08, 24'h0);
    wait_idle();
    check_eq("bs_count", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      check_eq("q_write", 64'(wq[0]), 64'({14'h080, 32'h0000ff51}));
      check_eq("bs_write", 64'(wq[1]), 64'({14'h080, 32'h00000020}));
    end
    check_cur("bs", 0, 1);

    // Full clear with CPU stealing every other cycle; clear beats a byte
    wq.delete();
    clr_req  = 1'b1;
    ch_valid = 1'b1;
    ch_data  = 8'h4B;
    #1;
    check_eq("clr_ready", 64'(ch_ready), 64'd0);
    tick();
    clr_req  = 1'b0;
    ch_valid = 1'b0;
    cpu_a    = 14'h3ffc;
    cpu_wd   = 32'hdeadbeef;
    cyc = 0;
    while (busy && cyc < 3000) begin
      cpu_we = cyc[0];
      tick();
      cyc++;
    end
    cpu_we = 1'b0;
    tick();
    check_eq("clr_cycles", 64'(cyc), 64'd1535);
    n_fill = 0;
    n_cpu = 0;
    n_order = 0;
    foreach (wq[i]) begin
      if (wq[i][31:0] == 32'h00000020) begin
        if (wq[i][45:32] != 14'(n_fill * 4)) n_order++;
        n_fill++;
      end else if (wq[i] == {14'h3ffc, 32'hdeadbeef}) begin
        n_cpu++;
      end
    end
    check_eq("clr_fill", 64'(n_fill), 64'd768);
    check_eq("clr_order", 64'(n_order), 64'd0);
    check_eq("clr_cpu", 64'(n_cpu), 64'd767);
    check_eq("clr_total", 64'(wq.size()), 64'd1535);
    check_cur("clr", 0, 0);
    check_eq("clr_ready_end", 64'(ch_ready), 64'd1);

`ifdef VRAM_LINE_AUTOCLR_EN
    send(8'h0A, 24'h0);
    wait_idle();
    send(8'h0A, 24'h0);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      send(8'h79, 24'h0);
      wait_idle();
    end
    check_cur("lclr_pre", 5, 2);
    wq.delete();
    send(8'h0A, 24'h0);
    wait_idle();
    check_eq("lclr_count", 64'(wq.size()), 64'd32);
    n_order = 0;
    foreach (wq[i]) begin
      if (wq[i] != {14'((96 + i) * 4), 32'h00000020}) n_order++;
    end
    check_eq("lclr_order", 64'(n_order), 64'd0);
    check_eq("lclr_ready", 64'(ch_ready), 64'd1);
    check_cur("lclr", 0, 3);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
